// File: rtl/relu_maxpool_stream.sv
// relu_maxpool_stream
//   Streaming ReLU + 2x2/stride-2 max-pool stage that sits behind the conv layer.
//   Pixels arrive one per accepted beat, channel-major and then raster order
//   (row, col) inside each channel. One pooled pixel leaves per 2x2 window, in the
//   same order. Samples are signed fixed point (DATA_W bits, FRAC fractional bits).
//   Pooling and ReLU never rescale, so FRAC only describes the number format.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    conv output pixel, signed
//   in_valid   in_data is valid
//   in_ready   stage accepts in_data this cycle (= !out_valid | out_ready)
//   out_data   pooled (and optionally ReLU'd) pixel, signed
//   out_valid  out_data is valid
//   out_ready  consumer accepts out_data
//   out_last   with out_valid: last pooled pixel of the last channel of a frame
module relu_maxpool_stream #(
    parameter int DATA_W    = 18,
    parameter int FRAC      = 9,
    parameter int DEPTH     = 32,
    parameter int IN_HEIGHT = 5,
    parameter int IN_WIDTH  = 5,
    parameter int RELU_EN   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    localparam int OUT_H = IN_HEIGHT / 2;
    localparam int OUT_W = IN_WIDTH / 2;
    localparam int COL_W = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int CH_W  = (DEPTH     > 1) ? $clog2(DEPTH)     : 1;
    localparam int IDX_W = (OUT_W     > 1) ? $clog2(OUT_W)     : 1;

    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(IN_HEIGHT - 1);
    localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(DEPTH - 1);
    // Last column/row that still belongs to a full 2x2 window; a trailing odd
    // column/row lies beyond these and is counted but otherwise ignored.
    localparam logic [COL_W-1:0] COL_WIN_LAST = COL_W'(2 * OUT_W - 1);
    localparam logic [ROW_W-1:0] ROW_WIN_LAST = ROW_W'(2 * OUT_H - 1);

    if (IN_HEIGHT < 2 || IN_WIDTH < 2 || DEPTH < 1 || FRAC >= DATA_W) begin : g_bad_params
        $error("relu_maxpool_stream: illegal parameter combination");
    end

    function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic signed [DATA_W-1:0] hold_q, hold_d;
    logic signed [DATA_W-1:0] rowbuf_q [OUT_W];
    logic signed [DATA_W-1:0] rowbuf_d [OUT_W];
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;

    logic                     in_fire;
    logic                     in_window;
    logic [IDX_W-1:0]         buf_idx;
    logic signed [DATA_W-1:0] pair_max;
    logic signed [DATA_W-1:0] win_max;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        col_d       = col_q;
        row_d       = row_q;
        ch_d        = ch_q;
        hold_d      = hold_q;
        rowbuf_d    = rowbuf_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        in_fire   = in_valid && in_ready;
        in_window = (col_q <= COL_WIN_LAST) && (row_q <= ROW_WIN_LAST);
        buf_idx   = IDX_W'(col_q >> 1);
        pair_max  = smax(hold_q, in_data);
        win_max   = smax(rowbuf_q[buf_idx], pair_max);

        // A transfer empties the output register; a completing beat in the same
        // cycle refills it below.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (in_fire) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                    ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end

            if (in_window) begin
                if (!col_q[0]) begin
                    hold_d = in_data;
                end else if (!row_q[0]) begin
                    rowbuf_d[buf_idx] = pair_max;
                end else begin
                    out_data_d  = (RELU_EN != 0 && win_max[DATA_W-1]) ? '0 : win_max;
                    out_valid_d = 1'b1;
                    out_last_d  = (ch_q == CH_LAST) && (row_q == ROW_WIN_LAST) &&
                                  (col_q == COL_WIN_LAST);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            ch_q        <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // NOTE: the row buffer has no reset: each entry is written on an even row
    // before the odd row of the same channel reads it.
    always_ff @(posedge clk) begin
        rowbuf_q <= rowbuf_d;
    end

endmodule

// File: tb/tb_relu_maxpool_stream.sv
module tb_relu_maxpool_stream;

    localparam int DW = 18;
    localparam int IH = 5;
    localparam int IW = 5;
    localparam int OH = IH / 2;
    localparam int OW = IW / 2;
    localparam int FR = IH * IW;

    typedef struct packed {
        logic                 last;
        logic signed [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic sel;                    // 0: 32-channel ReLU unit, 1: 1-channel pass-through unit
    logic in_valid;
    logic signed [DW-1:0] in_data;
    logic out_ready;

    logic a_in_valid, a_in_ready, a_out_valid, a_out_last;
    logic b_in_valid, b_in_ready, b_out_valid, b_out_last;
    logic signed [DW-1:0] a_out_data, b_out_data;
    logic o_valid, o_last, o_in_ready;
    logic signed [DW-1:0] o_data;

    always #5 clk = ~clk;

    assign a_in_valid = in_valid && !sel;
    assign b_in_valid = in_valid && sel;
    assign o_valid    = sel ? b_out_valid : a_out_valid;
    assign o_last     = sel ? b_out_last  : a_out_last;
    assign o_data     = sel ? b_out_data  : a_out_data;
    assign o_in_ready = sel ? b_in_ready  : a_in_ready;

    relu_maxpool_stream #(.DATA_W(DW), .FRAC(9), .DEPTH(32), .IN_HEIGHT(IH),
                          .IN_WIDTH(IW), .RELU_EN(1)) u_main (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (a_in_valid),
        .in_ready (a_in_ready),
        .out_data (a_out_data),
        .out_valid(a_out_valid),
        .out_ready(out_ready),
        .out_last (a_out_last)
    );

    relu_maxpool_stream #(.DATA_W(DW), .FRAC(9), .DEPTH(1), .IN_HEIGHT(IH),
                          .IN_WIDTH(IW), .RELU_EN(0)) u_small (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .out_data (b_out_data),
        .out_valid(b_out_valid),
        .out_ready(out_ready),
        .out_last (b_out_last)
    );

    int total = 0;
    int bad   = 0;
    int beat_idx;
    logic signed [DW-1:0] stim_q[$];
    beat_t got_q[$];
    beat_t exp_q[$];

    // Reference: each group of FR beats is one channel; pooled value is the
    // max over each full 2x2 window, optionally clamped at zero.
    function automatic void build_model(input int depth, input bit relu);
        logic signed [DW-1:0] m, v;
        beat_t e;
        exp_q.delete();
        for (int c = 0; c < stim_q.size() / FR; c++) begin
            for (int orow = 0; orow < OH; orow++) begin
                for (int ocol = 0; ocol < OW; ocol++) begin
                    m = stim_q[c*FR + (2*orow)*IW + 2*ocol];
                    for (int dr = 0; dr < 2; dr++) begin
                        for (int dc = 0; dc < 2; dc++) begin
                            v = stim_q[c*FR + (2*orow+dr)*IW + 2*ocol + dc];
                            if (v > m) m = v;
                        end
                    end
                    if (relu && m < 0) m = '0;
                    e.data = m;
                    e.last = ((c % depth) == depth-1) && (orow == OH-1) && (ocol == OW-1);
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        beat_idx  = 0;
        stim_q.delete();
        got_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at the falling edge, sample settled outputs 1 time unit later,
    // then log the output transfer / input acceptance that the next rising edge performs.
    task automatic cycle(input bit v, input bit r);
        beat_t b;
        @(negedge clk);
        in_valid  = v && (beat_idx < stim_q.size());
        in_data   = in_valid ? stim_q[beat_idx] : '0;
        out_ready = r;
        #1;
        if (o_valid && out_ready) begin
            b.last = o_last;
            b.data = o_data;
            got_q.push_back(b);
        end
        if (in_valid && o_in_ready) beat_idx++;
    endtask

    task automatic run(input int vpct, input int rpct, input int n_out, input int budget,
                       output bit timed_out);
        int cyc = 0;
        timed_out = 1'b0;
        while (beat_idx < stim_q.size() || got_q.size() < n_out) begin
            if (cyc >= budget) begin
                timed_out = 1'b1;
                break;
            end
            cycle($urandom_range(99) < vpct, $urandom_range(99) < rpct);
            cyc++;
        end
        repeat (4) cycle(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_in_valid: got %b want 0", a_out_valid); end
        do_reset();
        #1;
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        total++; if (a_out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", a_out_last); end
        total++; if (a_out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %0d want 0", a_out_data); end
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL reset_small_valid: got %b want 0", b_out_valid); end
        total++; if (b_out_data !== '0) begin bad++; $display("FAIL reset_small_data: got %0d want 0", b_out_data); end
    endtask

    task automatic test_ramp();
        int exp_v[4] = '{3072, 4096, 8192, 9216};
        bit to;
        sel = 1'b1;
        do_reset();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) stim_q.push_back(DW'((5*r + c) << 9));
        run(100, 100, 4, 200, to);
        total++; if (to) begin bad++; $display("FAIL ramp_timeout: got %0d outputs want 4", got_q.size()); end
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL ramp_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].data !== DW'(exp_v[i]) || got_q[i].last !== (i == 3)) begin
                bad++;
                $display("FAIL ramp_out%0d: got %0d/last=%b want %0d/last=%b", i,
                         got_q[i].data, got_q[i].last, exp_v[i], (i == 3));
            end
        end
    endtask

    task automatic test_negative();
        bit to;
        // ReLU unit: all -1.0 clamps to 0
        sel = 1'b0;
        do_reset();
        repeat (FR) stim_q.push_back(DW'(-512));
        run(100, 100, 4, 200, to);
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL neg_relu_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++;
            if (got_q[i].data !== '0 || got_q[i].last !== 1'b0) begin
                bad++; $display("FAIL neg_relu_out%0d: got %0d/last=%b want 0/last=0", i, got_q[i].data, got_q[i].last);
            end
        end
        // Pass-through unit: all -1.0 stays -512
        sel = 1'b1;
        do_reset();
        repeat (FR) stim_q.push_back(DW'(-512));
        run(100, 100, 4, 200, to);
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL neg_pass_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++;
            if (got_q[i].data !== DW'(-512) || got_q[i].last !== (i == 3)) begin
                bad++; $display("FAIL neg_pass_out%0d: got %0d/last=%b want -512/last=%b", i, got_q[i].data, got_q[i].last, (i == 3));
            end
        end
        // Mixed first window {-512, 256, -1, 0}
        sel = 1'b0;
        do_reset();
        repeat (FR) stim_q.push_back(DW'(-512));
        stim_q[1] = DW'(256);
        stim_q[IW] = DW'(-1);
        stim_q[IW+1] = '0;
        run(100, 100, 4, 200, to);
        total++;
        if (got_q.size() < 1 || got_q[0].data !== DW'(256)) begin
            bad++; $display("FAIL neg_mixed: got %0d want 256", (got_q.size() > 0) ? int'(got_q[0].data) : -1);
        end
    endtask

    task automatic test_random_frames();
        bit to;
        int n_last = 0;
        sel = 1'b0;
        do_reset();
        repeat (32 * FR) stim_q.push_back(DW'($urandom));
        for (int i = 0; i < 32 * FR; i++) stim_q.push_back(stim_q[i]);
        build_model(32, 1'b1);
        run(60, 60, 256, 20000, to);
        total++; if (to) begin bad++; $display("FAIL rand_timeout: got %0d outputs want 256", got_q.size()); end
        total++; if (got_q.size() != 256) begin bad++; $display("FAIL rand_count: got %0d want 256", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i].last) n_last++;
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rand_out%0d: got %0d/last=%b want %0d/last=%b", i,
                                got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
        total++; if (n_last != 2) begin bad++; $display("FAIL rand_last_count: got %0d want 2", n_last); end
    endtask

    task automatic test_backpressure();
        bit to;
        int guard = 0;
        sel = 1'b0;
        do_reset();
        repeat (FR) stim_q.push_back(DW'($urandom));
        build_model(32, 1'b1);
        while (beat_idx < IW + 2 && guard < 100) begin
            cycle(1'b1, 1'b1);
            guard++;
        end
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b0);
            total++;
            if (o_valid !== 1'b1 || o_in_ready !== 1'b0 || o_data !== exp_q[0].data) begin
                bad++; $display("FAIL bp_stall%0d: got valid=%b ready=%b data=%0d want valid=1 ready=0 data=%0d",
                                k, o_valid, o_in_ready, o_data, exp_q[0].data);
            end
        end
        run(100, 100, 4, 200, to);
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL bp_out%0d: got %0d want %0d", i, got_q[i].data, exp_q[i].data);
            end
        end
    endtask

    task automatic test_odd_edge();
        bit to;
        int idx;
        int guard = 0;
        sel = 1'b0;
        do_reset();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                stim_q.push_back((r == IH-1 || c == IW-1) ? DW'(18'h1FFFF)
                                                          : DW'(int'($urandom_range(2000)) - 1000));
        build_model(32, 1'b1);
        while (beat_idx < FR && guard < 200) begin
            idx = beat_idx;
            cycle(1'b1, 1'b1);
            if ((idx / IW == IH-1 || idx % IW == IW-1) && !o_valid) begin
                total++;
                if (o_in_ready !== 1'b1) begin bad++; $display("FAIL odd_ready%0d: got %b want 1", idx, o_in_ready); end
            end
            guard++;
        end
        run(100, 100, 4, 200, to);
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL odd_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || got_q[i].data === DW'(18'h1FFFF)) begin
                bad++; $display("FAIL odd_out%0d: got %0d want %0d", i, got_q[i].data, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int exp_v[4] = '{3072, 4096, 8192, 9216};
        bit to;
        int guard = 0;
        sel = 1'b0;
        do_reset();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) stim_q.push_back(DW'((5*r + c) << 9));
        while (beat_idx < IW + 4 && guard < 100) begin
            cycle(1'b1, 1'b1);
            guard++;
        end
        cycle(1'b0, 1'b0);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL mid_pending: got %b want 1", o_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || o_data !== '0) begin
            bad++; $display("FAIL mid_async_drop: got valid=%b last=%b data=%0d want 0/0/0", o_valid, o_last, o_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        beat_idx = 0;
        got_q.delete();
        run(100, 100, 4, 200, to);
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL mid_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].data !== DW'(exp_v[i]) || got_q[i].last !== 1'b0) begin
                bad++; $display("FAIL mid_out%0d: got %0d want %0d", i, got_q[i].data, exp_v[i]);
            end
        end
    endtask

    initial begin
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_ramp();
        test_negative();
        test_random_frames();
        test_backpressure();
        test_odd_edge();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
